// File: rtl/shift_add_multiplier.sv
// Iterative unsigned multiplier: one ripple-carry add per cycle over a fixed
// shift-and-add sequence, with a start/busy/done handshake for pipeline stalls.

module ripple_carry_adder #(
   parameter int unsigned WIDTH = 32
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             carry_in,
   output logic [WIDTH-1:0] sum,
   output logic             carry_flag,
   output logic             overflow_flag
);

   logic [WIDTH:0] carry;

   // Bit-serial carry chain; the loop unrolls into WIDTH full-adder cells.
   always_comb begin
      carry    = '0;
      sum      = '0;
      carry[0] = carry_in;
      for (int i = 0; i < int'(WIDTH); i++) begin
         sum[i]       = a[i] ^ b[i] ^ carry[i];
         carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
      end
   end

   assign carry_flag    = carry[WIDTH];
   assign overflow_flag = carry[WIDTH] ^ carry[WIDTH-1];

endmodule

module shift_add_multiplier #(
   parameter int unsigned WIDTH = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [WIDTH-1:0]   multiplicand,
   input  logic [WIDTH-1:0]   multiplier,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] product,
   output logic               hi_nonzero
);

   localparam int unsigned ACC_W = 2 * WIDTH;
   localparam int unsigned CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t             state_q;
   state_t             state_d;
   logic [WIDTH-1:0]   mcand_q;
   logic [ACC_W-1:0]   acc_q;
   logic [CNT_W-1:0]   count_q;

   logic [WIDTH-1:0]   add_b;
   logic [WIDTH-1:0]   add_sum;
   logic               add_carry;
   logic               ovf_unused;
   logic [ACC_W-1:0]   acc_next;

   logic               accept_c;
   logic               iterate_c;
   logic               finish_c;
   logic               busy_d;
   logic               done_d;

   // Multiplicand is added into the upper half only when the current LSB is set.
   assign add_b = acc_q[0] ? mcand_q : '0;

   ripple_carry_adder #(
      .WIDTH (WIDTH)
   ) u_adder (
      .a             (acc_q[ACC_W-1:WIDTH]),
      .b             (add_b),
      .carry_in      (1'b0),
      .sum           (add_sum),
      .carry_flag    (add_carry),
      .overflow_flag (ovf_unused)
   );

   assign acc_next = {add_carry, add_sum, acc_q[WIDTH-1:1]};

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (start) state_d = RUN;
         RUN:     if (count_q == LAST_ITER) state_d = DONE;
         DONE:    state_d = start ? RUN : IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Control strobes plus next values of the registered status outputs.
   always_comb begin
      accept_c  = 1'b0;
      iterate_c = 1'b0;
      finish_c  = 1'b0;
      busy_d    = (state_d == RUN);
      done_d    = (state_d == DONE);
      unique case (state_q)
         IDLE:    accept_c = start;
         RUN: begin
            iterate_c = 1'b1;
            finish_c  = (count_q == LAST_ITER);
         end
         DONE:    accept_c = start;
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mcand_q    <= '0;
         acc_q      <= '0;
         count_q    <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         product    <= '0;
         hi_nonzero <= 1'b0;
      end else begin
         busy <= busy_d;
         done <= done_d;
         if (accept_c) begin
            mcand_q <= multiplicand;
            acc_q   <= {{WIDTH{1'b0}}, multiplier};
            count_q <= '0;
         end else if (iterate_c) begin
            acc_q   <= acc_next;
            count_q <= count_q + CNT_W'(1);
         end
         if (finish_c) begin
            product    <= acc_next;
            hi_nonzero <= |acc_next[ACC_W-1:WIDTH];
         end
      end
   end

endmodule

// File: doc/shift_add_multiplier.md
# shift_add_multiplier

Iterative 32x32 unsigned multiplier for the mini CPU execute stage. It computes a 64-bit product over a fixed 32-cycle shift-and-add sequence, and issues exactly one 32-bit add per cycle through a single instance of the team's 32-bit ripple-carry adder. It uses a start/busy/done handshake so the CPU control unit can stall the pipeline while a MUL instruction is in flight.

## Interface
Parameters:
- WIDTH, 32, operand width; product is 2*WIDTH. Only 32 is supported, matching the adder instance.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a multiply. Sampled only when busy=0.
- multiplicand  input  32  operand A, latched on an accepted start.
- multiplier  input  32  operand B, latched on an accepted start.
- busy  output  1  high while the sequence is running.
- done  output  1  single-cycle pulse when product is valid.
- product  output  64  registered A*B; holds its value until the next completion.
- hi_nonzero  output  1  registered; 1 when product[63:32] != 0 (truncation to 32 bits loses information).

## Operation
- Reset (rst=1 at an edge) takes priority over all else:
  - state=IDLE, busy=0, done=0, product=0, hi_nonzero=0, internal registers=0.
  - Reset during RUN aborts the operation. No done is generated and product is unchanged from 0.
- States: IDLE, RUN, DONE.
- IDLE, start=1 → RUN:
  - mcand ← multiplicand.
  - acc ← {32'b0, multiplier}.
  - count ← 0.
- RUN, each cycle:
  - Adder inputs: A=acc[63:32], B = acc[0] ? mcand : 32'b0.
  - Adder outputs: sum and carry_flag (overflow_flag is unused).
  - acc ← {carry_flag, sum, acc[31:1]}.
  - count ← count+1.
  - When count==31 (32nd iteration):
    - product ← next acc value.
    - hi_nonzero ← (next acc[63:32] != 0).
    - go to DONE.
- DONE (one cycle): done=1, busy=0.
  - start=1 → behaves exactly as the IDLE accept and goes to RUN. Back-to-back operation with no bubble.
  - Otherwise → IDLE.
- start while busy=1 is ignored. Operand inputs are not re-sampled during RUN.
- Arithmetic is unsigned modulo 2^64. The result is exact for all 32-bit operands; no overflow of the 64-bit product is possible.

## Timing
- Start accepted at edge E0. busy=1 after E0 and stays 1 through the cycle before E32.
- Iterations occur at edges E1..E32.
- After E32: done=1, busy=0, product and hi_nonzero valid. Latency from start edge to done is 32 cycles.
- done falls after E33, unless a new start was accepted at E33; even then done falls, because state is RUN.
- Throughput: one multiply per 33 cycles when start is held high continuously.
- busy and done are never high in the same cycle. done is never high for two consecutive cycles.
- The adder path is the critical path: 32-bit ripple add plus mux, within one cycle. There is no multicycle constraint.

## Test plan
- Reset, then A=3, B=5, start for 1 cycle → done after 32 cycles; product=64'd15, hi_nonzero=0. busy was high for exactly 32 cycles.
- A=0xFFFFFFFF, B=0xFFFFFFFF → product=0xFFFFFFFE00000001, hi_nonzero=1. This exercises carry_flag into bit 63.
- Start with A=0x12345678, B=0x9ABCDEF0, then pulse start with A=1, B=1 at cycle 10 → second request ignored; product=0x0B00EA4E242D2080.
- Hold start=1 with A=0x10000, B=0x10000, then in the DONE cycle change operands to A=7, B=6 → first product=0x100000000, hi_nonzero=1. The second run starts with no idle cycle and yields 42 with hi_nonzero=0, 33 cycles later.
- Assert rst at cycle 15 of a run → busy=0, done never pulses, product=0. A following start with A=0, B=0xDEADBEEF gives product=0.
- Random unsigned A, B (≥1000 pairs) → product equals the 64-bit reference model. hi_nonzero equals (A*B ≥ 2^32).
